// File: rtl/regfile_sb.sv
// regfile_sb: multi-port general-purpose register file with an integrated
// busy-bit scoreboard. Reads are combinational with write-back bypass. Two
// write-back ports update registers on the rising edge. Busy bits are set
// at issue and cleared at write-back so decode can spot RAW hazards.
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NRD*ADDR_W-1:0]   rd_addr,
  output logic [NRD*DATA_W-1:0]   rd_data,
  output logic [NRD-1:0]          rd_busy,
  output logic                    hazard,
  input  logic [NRD-1:0]          rd_en,
  input  logic [1:0]              wr_en,
  input  logic [2*ADDR_W-1:0]     wr_addr,
  input  logic [2*DATA_W-1:0]     wr_data,
  input  logic                    iss_en,
  input  logic [ADDR_W-1:0]       iss_addr,
  input  logic                    flush,
  output logic [ADDR_W:0]         pend_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic [DEPTH-1:0]  wb_hit;
  logic [ADDR_W:0]   busy_cnt;

  logic [ADDR_W-1:0] wa0, wa1;
  logic [DATA_W-1:0] wd0, wd1;
  logic [1:0]        wv;

  assign wa0 = wr_addr[ADDR_W-1:0];
  assign wa1 = wr_addr[2*ADDR_W-1:ADDR_W];
  assign wd0 = wr_data[DATA_W-1:0];
  assign wd1 = wr_data[2*DATA_W-1:DATA_W];

  // A write to register 0 is dropped everywhere, so it never counts as valid.
  assign wv = {wr_en[1] && (wa1 != '0), wr_en[0] && (wa0 != '0)};

  // One-hot map of registers receiving a write-back this cycle.
  always_comb begin
    wb_hit = '0;
    if (wv[0]) wb_hit[wa0] = 1'b1;
    if (wv[1]) wb_hit[wa1] = 1'b1;
  end

  // Busy next-state: flush and write-back clear, issue sets last so it wins.
  always_comb begin
    busy_nxt = busy & ~wb_hit;
    if (flush) busy_nxt = '0;
    if (iss_en && (iss_addr != '0)) busy_nxt[iss_addr] = 1'b1;
  end

  // Population count of the next busy vector, registered as pend_cnt.
  always_comb begin
    busy_cnt = '0;
    for (int r = 0; r < DEPTH; r++) begin
      busy_cnt = busy_cnt + (ADDR_W+1)'(busy_nxt[r]);
    end
  end

  // Read ports: register 0 reads zero; port 1 write data beats port 0, which
  // beats stored state. A register being written back is no longer busy.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              nz;
    assign ra = rd_addr[k*ADDR_W +: ADDR_W];
    assign nz = (ra != '0);
    assign rd_data[k*DATA_W +: DATA_W] =
        !nz                      ? '0  :
        (wv[1] && (wa1 == ra))   ? wd1 :
        (wv[0] && (wa0 == ra))   ? wd0 :
                                   regs[ra];
    assign rd_busy[k] = nz && busy[ra] && !wb_hit[ra];
  end

  assign hazard = |(rd_busy & rd_en);

  // Register storage; port 1 is written second so it wins an address clash.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
    end else begin
      if (wv[0]) regs[wa0] <= wd0;
      if (wv[1]) regs[wa1] <= wd1;
    end
  end

  // Scoreboard state and its registered occupancy count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      busy     <= '0;
      pend_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      pend_cnt <= busy_cnt;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: scoreboard-driven bench for regfile_sb. A behavioural model
// predicts every output; predictions are queued when stimulus is driven and
// popped when the DUT outputs are sampled.
module tb_regfile_sb;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NRD    = 4;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_busy;
  logic                  hazard;
  logic [NRD-1:0]        rd_en;
  logic [1:0]            wr_en;
  logic [2*ADDR_W-1:0]   wr_addr;
  logic [2*DATA_W-1:0]   wr_data;
  logic                  iss_en;
  logic [ADDR_W-1:0]     iss_addr;
  logic                  flush;
  logic [ADDR_W:0]       pend_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  string       tag_q[$];
  logic [31:0] exp_q[$];

  logic [31:0] m_regs [32];
  logic [31:0] m_busy;

  // Free-running clock
  always #5 clk = ~clk;

  regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NRD(NRD)) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .hazard(hazard), .rd_en(rd_en), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
    .iss_addr(iss_addr), .flush(flush), .pend_cnt(pend_cnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic pushExp(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic popCheck(input logic [31:0] got);
    if (exp_q.size() == 0) begin
      n_vec++;
      n_miss++;
      $display("[TB] FAIL sb_underflow: got %h, expected nothing queued", got);
    end else begin
      checkOutput(tag_q.pop_front(), got, exp_q.pop_front());
    end
  endtask

  function automatic logic wbTo(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    return (wr_en[0] && wr_addr[4:0] == a) || (wr_en[1] && wr_addr[9:5] == a);
  endfunction

  function automatic logic [31:0] mRead(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (wr_en[1] && wr_addr[9:5] == a) return wr_data[63:32];
    if (wr_en[0] && wr_addr[4:0] == a) return wr_data[31:0];
    return m_regs[a];
  endfunction

  function automatic logic mBusy(input logic [4:0] a);
    return (a != 5'd0) && m_busy[a] && !wbTo(a);
  endfunction

  task automatic modelEdge();
    logic [31:0] nb;
    if (!reset) begin
      for (int r = 0; r < 32; r++) m_regs[r] = 32'h0;
      m_busy = 32'h0;
    end else begin
      nb = m_busy;
      if (flush) nb = 32'h0;
      for (int r = 1; r < 32; r++) if (wbTo(5'(r))) nb[r] = 1'b0;
      if (iss_en && iss_addr != 5'd0) nb[iss_addr] = 1'b1;
      if (wr_en[0] && wr_addr[4:0] != 5'd0) m_regs[wr_addr[4:0]] = wr_data[31:0];
      if (wr_en[1] && wr_addr[9:5] != 5'd0) m_regs[wr_addr[9:5]] = wr_data[63:32];
      m_busy = nb;
    end
  endtask

  task automatic idle();
    reset = 1'b1; rd_addr = '0; rd_en = '0; wr_en = '0; wr_addr = '0;
    wr_data = '0; iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
  endtask

  task automatic setRd(input int k, input logic [4:0] a, input logic en);
    rd_addr[k*ADDR_W +: ADDR_W] = a;
    rd_en[k] = en;
  endtask

  task automatic setWr(input int p, input logic [4:0] a, input logic [31:0] d);
    wr_en[p] = 1'b1;
    wr_addr[p*ADDR_W +: ADDR_W] = a;
    wr_data[p*DATA_W +: DATA_W] = d;
  endtask

  // One cycle: predict combinational outputs, sample them mid-cycle, clock,
  // then predict and sample the registered count.
  task automatic applyStimulus();
    logic h;
    logic [4:0] a;
    h = 1'b0;
    for (int k = 0; k < NRD; k++) begin
      a = rd_addr[k*ADDR_W +: ADDR_W];
      pushExp($sformatf("rd_data%0d@%0d", k, a), mRead(a));
      pushExp($sformatf("rd_busy%0d@%0d", k, a), {31'b0, mBusy(a)});
      if (rd_en[k] && mBusy(a)) h = 1'b1;
    end
    pushExp("hazard", {31'b0, h});
    #2;
    for (int k = 0; k < NRD; k++) begin
      popCheck(rd_data[k*DATA_W +: DATA_W]);
      popCheck({31'b0, rd_busy[k]});
    end
    popCheck({31'b0, hazard});
    @(posedge clk);
    modelEdge();
    pushExp("pend_cnt", 32'($countones(m_busy)));
    #1;
    popCheck({26'b0, pend_cnt});
  endtask

  task automatic readAll();
    for (int b = 0; b < 32; b += 4) begin
      idle();
      for (int k = 0; k < NRD; k++) setRd(k, 5'(b + k), 1'b1);
      applyStimulus();
    end
  endtask

  initial begin
    for (int r = 0; r < 32; r++) m_regs[r] = 32'h0;
    m_busy = 32'h0;
    idle();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    pushExp("pend_cnt_reset", 32'h0);
    popCheck({26'b0, pend_cnt});

    // Everything reads zero and idle after reset
    readAll();

    // Write with same-cycle bypass, then read from storage
    idle(); setWr(0, 5'd5, 32'hDEADBEEF); setRd(0, 5'd5, 1'b1); applyStimulus();
    idle(); setRd(0, 5'd5, 1'b1); applyStimulus();
    idle(); setWr(0, 5'd0, 32'h1234); setRd(0, 5'd0, 1'b1); setRd(1, 5'd5, 1'b1); applyStimulus();
    idle(); setRd(0, 5'd0, 1'b1); applyStimulus();

    // Dual write to the same address: port 1 wins
    idle(); setWr(0, 5'd7, 32'h11); setWr(1, 5'd7, 32'h22); setRd(0, 5'd7, 1'b1); applyStimulus();
    idle(); setRd(0, 5'd7, 1'b1); applyStimulus();

    // Issue then write-back through the scoreboard
    idle(); iss_en = 1'b1; iss_addr = 5'd9; applyStimulus();
    idle(); setRd(2, 5'd9, 1'b1); applyStimulus();
    idle(); setRd(2, 5'd9, 1'b1); setWr(1, 5'd9, 32'hAA); applyStimulus();
    idle(); setRd(2, 5'd9, 1'b1); applyStimulus();

    // Flush, issue and write-back together
    idle(); iss_en = 1'b1; iss_addr = 5'd3; applyStimulus();
    idle(); iss_en = 1'b1; iss_addr = 5'd4; applyStimulus();
    idle(); flush = 1'b1; iss_en = 1'b1; iss_addr = 5'd4; setWr(0, 5'd3, 32'h33);
    setRd(0, 5'd3, 1'b1); setRd(1, 5'd4, 1'b1); applyStimulus();
    idle(); setRd(0, 5'd3, 1'b1); setRd(1, 5'd4, 1'b1); applyStimulus();

    // Issue and write-back to the same register: it stays busy
    idle(); iss_en = 1'b1; iss_addr = 5'd6; setWr(0, 5'd6, 32'h66); setRd(3, 5'd6, 1'b1); applyStimulus();
    idle(); iss_en = 1'b1; iss_addr = 5'd6; setWr(1, 5'd6, 32'h67); setRd(3, 5'd6, 1'b1); applyStimulus();
    idle(); iss_en = 1'b1; iss_addr = 5'd10; setRd(3, 5'd6, 1'b1); applyStimulus();

    // Reset mid-operation with three busy registers and a pending write
    idle(); reset = 1'b0; setWr(0, 5'd11, 32'hBAD); setRd(0, 5'd10, 1'b1); applyStimulus();
    readAll();

    // Random traffic over a small address window for plenty of collisions
    for (int i = 0; i < 60; i++) begin
      idle();
      for (int k = 0; k < NRD; k++) setRd(k, 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      wr_en    = 2'($urandom_range(0, 3));
      wr_addr  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      wr_data  = {$urandom, $urandom};
      iss_en   = 1'($urandom_range(0, 1));
      iss_addr = 5'($urandom_range(0, 7));
      flush    = ($urandom_range(0, 9) == 0);
      reset    = ($urandom_range(0, 29) != 0);
      applyStimulus();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
